// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding and the {CPOL,CPHA} mode constants
// used by both ends of the link.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StTransfer,
        StHold,
        StDone
    } spi_state_e;

    localparam logic [1:0] SpiMode0 = 2'b00;
    localparam logic [1:0] SpiMode1 = 2'b01;
    localparam logic [1:0] SpiMode2 = 2'b10;
    localparam logic [1:0] SpiMode3 = 2'b11;

    function automatic logic mode_cpol(logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock generator: toggles spi_clk every CLK_DIV enabled cycles and flags whether
// each toggle is a leading (away from idle) or trailing (back to idle) edge.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic cpol_i,
    output logic spi_clk_o,
    output logic lead_tick_o,
    output logic trail_tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            spi_clk_q, spi_clk_d;
    logic            tick;

    assign tick = en_i && (cnt_q == CntMax);

    // Idle forces the counter to zero and the clock to its idle level, so every
    // enable window starts with a full half-period.
    always_comb begin
        cnt_d     = cnt_q;
        spi_clk_d = spi_clk_q;
        if (!en_i) begin
            cnt_d     = '0;
            spi_clk_d = cpol_i;
        end else if (tick) begin
            cnt_d     = '0;
            spi_clk_d = ~spi_clk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            spi_clk_q <= cpol_i;
        end else begin
            cnt_q     <= cnt_d;
            spi_clk_q <= spi_clk_d;
        end
    end

    assign spi_clk_o    = spi_clk_q;
    assign lead_tick_o  = tick && (spi_clk_q == cpol_i);
    assign trail_tick_o = tick && (spi_clk_q != cpol_i);

endmodule

// File: rtl/spi_master.sv
// SPI master: accepts a word on start, frames it with cs, shifts it out MSB-first on mosi
// while capturing miso, and returns the received word with a one-cycle done pulse.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_clk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic                  cs_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam logic [1:0] Mode = {CPOL, CPHA};
    localparam bit ModeCpha = mode_cpha(Mode);
    // CPHA=0 samples on leads, so the final trailing edge arrives after DATA_WIDTH samples.
    localparam logic [BitW-1:0] LastBit =
        ModeCpha ? BitW'(DATA_WIDTH - 1) : BitW'(DATA_WIDTH);

    spi_state_e state_q, state_d;

    logic [CntW-1:0]       wait_q, wait_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  mosi_q, mosi_d;

    logic lead_tick, trail_tick, sample_tick, shift_tick, last_edge, wait_done;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (state_q == StTransfer),
        .cpol_i      (mode_cpol(Mode)),
        .spi_clk_o   (spi_clk_o),
        .lead_tick_o (lead_tick),
        .trail_tick_o(trail_tick)
    );

    assign sample_tick = ModeCpha ? trail_tick : lead_tick;
    assign shift_tick  = ModeCpha ? lead_tick : trail_tick;
    assign last_edge   = trail_tick && (bit_q == LastBit);
    assign wait_done   = (wait_q == CntMax);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_i) state_d = StSetup;
            StSetup:    if (wait_done) state_d = StTransfer;
            StTransfer: if (last_edge) state_d = StHold;
            StHold:     if (wait_done) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        wait_d    = wait_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        mosi_d    = mosi_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    // CPHA=0 presents the MSB before the first clock edge.
                    tx_sh_d = ModeCpha ? tx_data_i : (tx_data_i << 1);
                    mosi_d  = ModeCpha ? 1'b0 : tx_data_i[DATA_WIDTH-1];
                    rx_sh_d = '0;
                    bit_d   = '0;
                    wait_d  = '0;
                end
            end
            StSetup: begin
                wait_d = wait_done ? '0 : wait_q + 1'b1;
            end
            StTransfer: begin
                if (sample_tick) begin
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso_i};
                    bit_d   = bit_q + 1'b1;
                end
                if (shift_tick && !last_edge) begin
                    mosi_d  = tx_sh_q[DATA_WIDTH-1];
                    tx_sh_d = tx_sh_q << 1;
                end
            end
            StHold: begin
                wait_d = wait_done ? '0 : wait_q + 1'b1;
                if (wait_done) begin
                    rx_data_d = rx_sh_q;
                    mosi_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cs_o   = 1'b1;
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            StSetup, StTransfer, StHold: begin
                cs_o   = 1'b0;
                busy_o = 1'b1;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign mosi_o    = mosi_q;
    assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: three instances (mode 0 div 2, mode 3 div 2, mode 0 div 1)
// exercised one at a time; a negedge monitor pops expectations on every done pulse.
module tb_spi_master;

    typedef struct {
        int         idx;
        logic [7:0] rx;
        logic [7:0] mo;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start   [3];
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];
    logic       busy    [3];
    logic       done    [3];
    logic       sclk    [3];
    logic       mosi    [3];
    logic       miso    [3];
    logic       cs      [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    logic       use_tgt = 1'b0;
    logic       gap_chk = 1'b0;
    logic [7:0] tgt_sh  = 8'h3C;
    logic       tgt_sp  = 1'b0;

    logic [7:0] cap       [3];
    int         rises     [3];
    int         last_rise [3];
    int         hi_run    [3];
    logic       sp        [3];
    logic       cp        [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Div = (g == 2) ? 1 : 2;
        localparam bit Pol = (g == 1);
        localparam bit Pha = (g == 1);
        spi_master #(
            .DATA_WIDTH(8),
            .CLK_DIV   (Div),
            .CPOL      (Pol),
            .CPHA      (Pha)
        ) u_dut (
            .clk_i    (clk),
            .reset_i  (reset),
            .start_i  (start[g]),
            .tx_data_i(tx_data[g]),
            .rx_data_o(rx_data[g]),
            .busy_o   (busy[g]),
            .done_o   (done[g]),
            .spi_clk_o(sclk[g]),
            .mosi_o   (mosi[g]),
            .miso_i   (miso[g]),
            .cs_o     (cs[g])
        );
    end

    assign miso[0] = use_tgt ? tgt_sh[7] : mosi[0];
    assign miso[1] = mosi[1];
    assign miso[2] = mosi[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 target: reloads 0x3C while deselected, shifts after each falling spi_clk.
    always @(posedge clk) begin
        if (cs[0]) tgt_sh <= 8'h3C;
        else if (tgt_sp && !sclk[0]) tgt_sh <= {tgt_sh[6:0], 1'b0};
        tgt_sp <= sclk[0];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: mosi capture on spi_clk rises, clock period, cs gap, and done scoreboard.
    initial begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            cap[i] = '0; rises[i] = 0; last_rise[i] = 0; hi_run[i] = 1000;
            sp[i] = 1'b0; cp[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!cs[i] && cp[i]) begin
                    cap[i]   = '0;
                    rises[i] = 0;
                    if (gap_chk && i == 0) chk("cs_high_gap", hi_run[i], 2);
                end
                if (cs[i]) hi_run[i]++;
                else hi_run[i] = 0;
                if (!cs[i] && sclk[i] && !sp[i]) begin
                    if (rises[i] > 0) chk("sclk_period", cyc - last_rise[i], (i == 2) ? 2 : 4);
                    last_rise[i] = cyc;
                    cap[i]       = {cap[i][6:0], mosi[i]};
                    rises[i]++;
                end
                if (done[i]) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: dut %0d at cycle %0d, expected none", i,
                                 cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_dut", i, e.idx);
                        chk("rx_data", rx_data[i], e.rx);
                        chk("mosi_bits", cap[i], e.mo);
                        chk("sclk_rises", rises[i], 8);
                        chk("done_cycle", cyc, e.cyc);
                        chk("done_cs_high", cs[i], 1'b1);
                        chk("done_not_busy", busy[i], 1'b0);
                        chk("done_mosi_low", mosi[i], 1'b0);
                    end
                end
                sp[i] = sclk[i];
                cp[i] = cs[i];
            end
        end
    end

    task automatic wait_done(input int i);
        int n = 0;
        while (!done[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done[i]) chk("done_timeout", 0, 1);
    endtask

    // Presents start in an IDLE cycle; done is expected lat cycles after that cycle.
    task automatic send(input int i, input logic [7:0] tx, input logic [7:0] rx_exp,
                        input int lat);
        exp_q.push_back('{i, rx_exp, tx, cyc + lat});
        tx_data[i] = tx;
        start[i]   = 1'b1;
        @(negedge clk);
        start[i]   = 1'b0;
        tx_data[i] = ~tx;
        chk("busy_after_start", busy[i], 1'b1);
        wait_done(i);
        @(negedge clk);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i]   = 1'b0;
            tx_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_cs", cs[i], 1'b1);
            chk("reset_sclk", sclk[i], (i == 1) ? 1'b1 : 1'b0);
            chk("reset_busy", busy[i], 1'b0);
            chk("reset_done", done[i], 1'b0);
            chk("reset_rx", rx_data[i], 8'h00);
            chk("reset_mosi", mosi[i], 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Mode 0 loopback
        send(0, 8'hA5, 8'hA5, 37);

        // Mode 0 behavioural target
        use_tgt = 1'b1;
        chk("idle_cs", cs[0], 1'b1);
        chk("idle_sclk_mode0", sclk[0], 1'b0);
        send(0, 8'hFF, 8'h3C, 37);
        use_tgt = 1'b0;

        // Mode 3 loopback
        chk("idle_sclk_mode3", sclk[1], 1'b1);
        send(1, 8'h81, 8'h81, 37);
        chk("idle_sclk_mode3_after", sclk[1], 1'b1);

        // start held high: three back-to-back frames
        k = cyc;
        exp_q.push_back('{0, 8'h01, 8'h01, k + 37});
        exp_q.push_back('{0, 8'h02, 8'h02, k + 75});
        exp_q.push_back('{0, 8'h03, 8'h03, k + 113});
        tx_data[0] = 8'h01;
        start[0]   = 1'b1;
        @(negedge clk);
        chk("b2b_busy1", busy[0], 1'b1);
        tx_data[0] = 8'h02;
        wait_done(0);
        gap_chk = 1'b1;
        repeat (2) @(negedge clk);
        chk("b2b_busy2", busy[0], 1'b1);
        tx_data[0] = 8'h03;
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("b2b_busy3", busy[0], 1'b1);
        start[0] = 1'b0;
        wait_done(0);
        gap_chk = 1'b0;
        repeat (60) @(negedge clk);

        // Reset 10 cycles into a transfer
        tx_data[0] = 8'h96;
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", busy[0], 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", cs[0], 1'b1);
        chk("abort_sclk", sclk[0], 1'b0);
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_rx", rx_data[0], 8'h00);
        chk("abort_done", done[0], 1'b0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        send(0, 8'h69, 8'h69, 37);

        // CLK_DIV=1 loopback
        send(2, 8'h5A, 8'h5A, 19);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
